// File: rtl/gb_lcd_capture.sv
// -----------------------------------------------------------------------------
// gb_lcd_capture
//
// Turns the GameBoy PPU 2-bit pixel stream into framebuffer write transactions
// for a double-buffered 160x144 framebuffer. Pixels are aligned to FRAME_START
// and written in raster order to the back bank (~disp_bank). When a bank is
// complete, frame_done pulses and disp_bank flips so the display side reads the
// new frame. While the LCD is off, the back bank is filled with white (2'b00)
// once, then the block idles until the LCD comes back on.
//
// Handshake: there is no backpressure. wr_en is a one-cycle write strobe that
// the framebuffer always accepts, so a write is complete in the cycle wr_en is
// high. wr_addr and wr_data are valid only while wr_en is high.
//
// Ports:
//   clk          GameBoy clock (only clock)
//   reset        synchronous, active-high
//   LD           pixel colour index from the PPU
//   PX_VALID     LD is valid this cycle
//   FRAME_START  one-cycle pulse marking the start of line 0
//   LCD_ON       LCDC enable from the PPU
//   wr_en        framebuffer write strobe (registered)
//   wr_addr      {bank, 15-bit pixel address} (registered)
//   wr_data      pixel written (registered)
//   disp_bank    bank holding the last complete frame
//   frame_done   one-cycle pulse, coincident with the final write of a bank
//   sync_err     sticky alignment error flag, cleared only by reset
//   o_dbg_state  current FSM state (IDLE=0, WAIT_SOF=1, CAPTURE=2, FILL=3)
// -----------------------------------------------------------------------------
module gb_lcd_capture #(
    parameter int GB_W      = 160,
    parameter int GB_H      = 144,
    parameter int FRAME_PIX = 23040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  LD,
    input  logic        PX_VALID,
    input  logic        FRAME_START,
    input  logic        LCD_ON,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [1:0]  wr_data,
    output logic        disp_bank,
    output logic        frame_done,
    output logic        sync_err,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_CAPTURE  = 2'd2,
        S_FILL     = 2'd3
    } state_t;

    localparam logic [7:0]  X_LAST    = 8'(GB_W - 1);
    localparam logic [7:0]  Y_LAST    = 8'(GB_H - 1);
    localparam logic [14:0] ADDR_LAST = 15'(FRAME_PIX - 1);

    state_t      r_state;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [14:0] r_addr;
    logic        r_filled;
    logic        r_wr_en;
    logic [15:0] r_wr_addr;
    logic [1:0]  r_wr_data;
    logic        r_disp_bank;
    logic        r_frame_done;
    logic        r_sync_err;

    state_t      w_state_nxt;
    logic [7:0]  w_x_nxt;
    logic [7:0]  w_y_nxt;
    logic [14:0] w_addr_nxt;
    logic        w_filled_nxt;
    logic        w_wr_en_nxt;
    logic [15:0] w_wr_addr_nxt;
    logic [1:0]  w_wr_data_nxt;
    logic        w_done_nxt;
    logic        w_err_set;

    logic        w_wr_bank;
    logic        w_restart;
    logic [7:0]  w_base_x;
    logic [7:0]  w_base_y;
    logic [14:0] w_base_addr;
    logic        w_base_last;
    logic [7:0]  w_inc_x;
    logic [7:0]  w_inc_y;
    logic [14:0] w_inc_addr;

    // disp_bank flips one edge after frame_done is shown. During that cycle the
    // flip is already committed, so the back bank must use the pending value
    // or a frame starting immediately would land in the bank being displayed.
    assign w_wr_bank = ~(r_disp_bank ^ r_frame_done);

    // A FRAME_START while aligned or capturing restarts the raster at (0,0);
    // a pixel in the same cycle is the first pixel of the new frame.
    assign w_restart   = FRAME_START && ((r_state == S_WAIT_SOF) || (r_state == S_CAPTURE));
    assign w_base_x    = w_restart ? 8'd0  : r_x;
    assign w_base_y    = w_restart ? 8'd0  : r_y;
    assign w_base_addr = w_restart ? 15'd0 : r_addr;
    assign w_base_last = (w_base_addr == ADDR_LAST);

    // Raster step; addr is a running count kept equal to y*GB_W + x.
    assign w_inc_x    = (w_base_x == X_LAST) ? 8'd0 : w_base_x + 8'd1;
    assign w_inc_y    = (w_base_x != X_LAST) ? w_base_y :
                        (w_base_y == Y_LAST) ? 8'd0 : w_base_y + 8'd1;
    assign w_inc_addr = w_base_addr + 15'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_addr_nxt    = r_addr;
        w_filled_nxt  = r_filled;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_done_nxt    = 1'b0;
        w_err_set     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (LCD_ON) begin
                    w_state_nxt  = S_WAIT_SOF;
                    w_filled_nxt = 1'b0;
                end else if (!r_filled) begin
                    // Blank the back bank once; after that, stay here.
                    w_state_nxt = S_FILL;
                    w_x_nxt     = 8'd0;
                    w_y_nxt     = 8'd0;
                    w_addr_nxt  = 15'd0;
                end
            end

            S_WAIT_SOF, S_CAPTURE: begin
                if (!LCD_ON) begin
                    // LCD off wins over everything: drop the partial frame.
                    w_state_nxt = S_FILL;
                    w_x_nxt     = 8'd0;
                    w_y_nxt     = 8'd0;
                    w_addr_nxt  = 15'd0;
                end else begin
                    if ((r_state == S_WAIT_SOF) && PX_VALID && !FRAME_START) begin
                        w_err_set = 1'b1;
                    end
                    if ((r_state == S_CAPTURE) && FRAME_START && (r_addr != 15'd0)) begin
                        w_err_set = 1'b1;
                    end
                    if (FRAME_START) begin
                        w_state_nxt = S_CAPTURE;
                        w_x_nxt     = 8'd0;
                        w_y_nxt     = 8'd0;
                        w_addr_nxt  = 15'd0;
                    end
                    if (PX_VALID && (FRAME_START || (r_state == S_CAPTURE))) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = {w_wr_bank, w_base_addr};
                        w_wr_data_nxt = LD;
                        if (w_base_last) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_WAIT_SOF;
                            w_x_nxt     = 8'd0;
                            w_y_nxt     = 8'd0;
                            w_addr_nxt  = 15'd0;
                        end else begin
                            w_state_nxt = S_CAPTURE;
                            w_x_nxt     = w_inc_x;
                            w_y_nxt     = w_inc_y;
                            w_addr_nxt  = w_inc_addr;
                        end
                    end
                end
            end

            S_FILL: begin
                if (LCD_ON) begin
                    // Abandon the blanking pass; the bank is not swapped.
                    w_state_nxt = S_WAIT_SOF;
                    w_x_nxt     = 8'd0;
                    w_y_nxt     = 8'd0;
                    w_addr_nxt  = 15'd0;
                end else begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = {w_wr_bank, r_addr};
                    w_wr_data_nxt = 2'b00;
                    if (w_base_last) begin
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = S_IDLE;
                        w_filled_nxt = 1'b1;
                        w_x_nxt      = 8'd0;
                        w_y_nxt      = 8'd0;
                        w_addr_nxt   = 15'd0;
                    end else begin
                        w_x_nxt    = w_inc_x;
                        w_y_nxt    = w_inc_y;
                        w_addr_nxt = w_inc_addr;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_x          <= 8'd0;
            r_y          <= 8'd0;
            r_addr       <= 15'd0;
            r_filled     <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 16'd0;
            r_wr_data    <= 2'b00;
            r_disp_bank  <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_addr       <= w_addr_nxt;
            r_filled     <= w_filled_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_frame_done <= w_done_nxt;
            // Flip on the edge after the final write is presented.
            if (r_frame_done) begin
                r_disp_bank <= ~r_disp_bank;
            end
            if (w_err_set) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign disp_bank   = r_disp_bank;
    assign frame_done  = r_frame_done;
    assign sync_err    = r_sync_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gb_lcd_capture.sv
// -----------------------------------------------------------------------------
// tb_gb_lcd_capture
//
// Reduced-size raster (32x10) so every scenario runs whole frames quickly.
// Stimulus tasks push the expected framebuffer writes into exp_q; a monitor
// pops one entry per observed wr_en and compares address, data and frame_done.
// Queue entry: {consec, frame_done, bank, addr[14:0], data[1:0]}; consec marks
// a write that must immediately follow another write (blanking pass).
// -----------------------------------------------------------------------------
module tb_gb_lcd_capture;

    localparam int W = 32;
    localparam int H = 10;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  LD;
    logic        PX_VALID;
    logic        FRAME_START;
    logic        LCD_ON;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [1:0]  wr_data;
    logic        disp_bank;
    logic        frame_done;
    logic        sync_err;
    logic [1:0]  o_dbg_state;

    gb_lcd_capture #(
        .GB_W      (W),
        .GB_H      (H),
        .FRAME_PIX (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .LD          (LD),
        .PX_VALID    (PX_VALID),
        .FRAME_START (FRAME_START),
        .LCD_ON      (LCD_ON),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .disp_bank   (disp_bank),
        .frame_done  (frame_done),
        .sync_err    (sync_err),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          vectors     = 0;
    int          miscompares = 0;
    logic [19:0] exp_q[$];

    // Reference model of what the display side should observe.
    bit          m_disp_bank = 1'b0;
    bit          m_sync_err  = 1'b0;

    // Blanking pass of unknown length (cut short by reset): checked as a
    // running address sequence instead of through the queue.
    bit          loose      = 1'b0;
    bit          loose_bank = 1'b0;
    int          loose_addr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit prev_wr    = 1'b0;
    bit fd_pending = 1'b0;
    bit fd_bank    = 1'b0;

    always @(negedge clk) begin : mon
        logic [19:0] e;
        logic        not_bank;
        if (reset) begin
            prev_wr    = 1'b0;
            fd_pending = 1'b0;
        end else begin
            if (fd_pending) begin
                check("disp_bank_after_done", {31'b0, disp_bank}, {31'b0, fd_bank});
                fd_pending = 1'b0;
            end
            if (wr_en) begin
                if (loose) begin
                    check("fill_write_before_reset", {13'b0, frame_done, wr_addr, wr_data},
                          {13'b0, 1'b0, loose_bank, 15'(loose_addr), 2'b00});
                    loose_addr++;
                end else if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got addr 0x%0h data %0d expected no write at %0t",
                             wr_addr, wr_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {13'b0, frame_done, wr_addr, wr_data}, {13'b0, e[18:0]});
                    if (e[19]) begin
                        check("fill_consecutive", {31'b0, prev_wr}, 32'd1);
                    end
                    if (e[18]) begin
                        not_bank = ~e[17];
                        check("disp_bank_at_done", {31'b0, disp_bank}, {31'b0, not_bank});
                        fd_pending = 1'b1;
                        fd_bank    = e[17];
                    end
                end
            end else if (frame_done) begin
                vectors++;
                miscompares++;
                $display("FAIL stray_frame_done: got frame_done=1 expected 0 without a write at %0t", $time);
            end
            prev_wr = wr_en;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        PX_VALID    = 1'b0;
        FRAME_START = 1'b0;
        repeat (n) tick();
    endtask

    // Sends FRAME_START (alone or with the first pixel) followed by 'count'
    // pixels in raster order with 0-3 idle cycles between them.
    task automatic send_pixels(input bit sof_with_pix, input int count, input bit ld_is_addr);
        bit         bank;
        int         p;
        logic [1:0] d;
        bank = ~m_disp_bank;
        if (!sof_with_pix) begin
            PX_VALID    = 1'b0;
            FRAME_START = 1'b1;
            tick();
            FRAME_START = 1'b0;
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                p = y * W + x;
                if (p < count) begin
                    if (!(sof_with_pix && p == 0)) idle($urandom_range(0, 3));
                    d           = ld_is_addr ? p[1:0] : 2'($urandom_range(0, 3));
                    LD          = d;
                    PX_VALID    = 1'b1;
                    FRAME_START = (p == 0) && sof_with_pix;
                    exp_q.push_back({1'b0, (p == N - 1), bank, 15'(p), d});
                    tick();
                    PX_VALID    = 1'b0;
                    FRAME_START = 1'b0;
                end
            end
        end
        if (count == N) m_disp_bank = ~m_disp_bank;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 4 * N + 100) begin
            tick();
            budget++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_drain: got %0d writes outstanding expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_status(input string name);
        drain(name);
        idle(3);
        check({name, "_disp_bank"}, {31'b0, disp_bank}, {31'b0, m_disp_bank});
        check({name, "_sync_err"}, {31'b0, sync_err}, {31'b0, m_sync_err});
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_wr_en"},      {31'b0, wr_en},      32'd0);
        check({name, "_wr_addr"},    {16'b0, wr_addr},    32'd0);
        check({name, "_wr_data"},    {30'b0, wr_data},    32'd0);
        check({name, "_disp_bank"},  {31'b0, disp_bank},  32'd0);
        check({name, "_frame_done"}, {31'b0, frame_done}, 32'd0);
        check({name, "_sync_err"},   {31'b0, sync_err},   32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        LCD_ON      = 1'b1;
        PX_VALID    = 1'b0;
        FRAME_START = 1'b0;
        LD          = 2'b00;
        repeat (3) tick();
        @(negedge clk);
        check_zero_outputs("reset");
        tick();
        reset = 1'b0;
        idle(2);

        // Nominal frame, LD = addr[1:0]; lands in bank 1.
        send_pixels(1'b0, N, 1'b1);
        check_status("frame1");

        // Second frame with the first pixel on FRAME_START; lands in bank 0.
        send_pixels(1'b1, N, 1'b0);
        check_status("frame2");

        // Early FRAME_START: partial frame abandoned, same bank restarts at 0.
        send_pixels(1'b0, 50, 1'b0);
        m_sync_err = 1'b1;
        send_pixels(1'b0, N, 1'b0);
        check_status("early_sof");

        // Early FRAME_START carrying a pixel.
        send_pixels(1'b0, 40, 1'b0);
        send_pixels(1'b1, N, 1'b0);
        check_status("early_sof_pix");

        // LCD drops mid-capture: one blanking pass of the back bank.
        send_pixels(1'b0, 30, 1'b0);
        LCD_ON = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({(i != 0), (i == N - 1), ~m_disp_bank, 15'(i), 2'b00});
        end
        m_disp_bank = ~m_disp_bank;
        for (int i = 0; i < N + 60; i++) begin
            LD          = 2'($urandom_range(0, 3));
            PX_VALID    = 1'($urandom_range(0, 1));
            FRAME_START = ($urandom_range(0, 15) == 0);
            tick();
        end
        check_status("lcd_off_fill");
        idle(40);
        check_status("fill_no_refill");

        // Reset in the middle of a blanking pass.
        LCD_ON = 1'b1;
        idle(2);
        loose_bank = ~m_disp_bank;
        loose_addr = 0;
        loose      = 1'b1;
        LCD_ON     = 1'b0;
        idle(25);
        reset  = 1'b1;
        LCD_ON = 1'b1;
        tick();
        @(negedge clk);
        check_zero_outputs("mid_fill_reset");
        check("fill_ran_before_reset", {31'b0, (loose_addr > 0)}, 32'd1);
        tick();
        reset       = 1'b0;
        loose       = 1'b0;
        m_disp_bank = 1'b0;
        m_sync_err  = 1'b0;
        idle(2);
        send_pixels(1'b0, N, 1'b0);
        check_status("after_reset_frame");

        // Pixels in WAIT_SOF with no FRAME_START: dropped, sync_err set.
        FRAME_START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            LD       = 2'($urandom_range(0, 3));
            PX_VALID = 1'b1;
            tick();
        end
        m_sync_err = 1'b1;
        idle(5);
        check_status("stray_pixels");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
